// File: rtl/axis_fifo_slice.sv
// AXI4-Stream FIFO slice: DEPTH-entry circular buffer with TLAST/TUSER sideband,
// registered ready/valid, fill level, almost-full flag and synchronous flush.
module axis_fifo_slice #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = DEPTH - 1
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic                         flush_i,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata_i,
  input  logic [USER_WIDTH-1:0]        s_axis_tuser_i,
  input  logic                         s_axis_tlast_i,
  input  logic                         s_axis_tvalid_i,
  output logic                         s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata_o,
  output logic [USER_WIDTH-1:0]        m_axis_tuser_o,
  output logic                         m_axis_tlast_o,
  output logic                         m_axis_tvalid_o,
  input  logic                         m_axis_tready_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         almost_full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_fifo_slice: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("axis_fifo_slice: AF_THRESH must be in 1..DEPTH");
  end

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [USER_WIDTH-1:0] user_mem [DEPTH];
  logic [DEPTH-1:0]      last_mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_next;
  logic                  push;
  logic                  pop;

  assign push = s_axis_tvalid_i & s_axis_tready_o;
  assign pop  = m_axis_tvalid_o & m_axis_tready_i;

  always_comb begin
    level_next = level_q;
    if (push && !pop) begin
      level_next = level_q + LW'(1);
    end else if (pop && !push) begin
      level_next = level_q - LW'(1);
    end
  end

  // Ready/valid/flags are all computed from level_next so they stay consistent with level_o.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level_q         <= '0;
      s_axis_tready_o <= 1'b0;
      m_axis_tvalid_o <= 1'b0;
      almost_full_o   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level_q         <= '0;
      s_axis_tready_o <= 1'b0;
      m_axis_tvalid_o <= 1'b0;
      almost_full_o   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level_q         <= level_next;
      s_axis_tready_o <= (level_next < DEPTH_L);
      m_axis_tvalid_o <= (level_next != '0);
      almost_full_o   <= (level_next >= AF_L);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        user_mem[i] <= '0;
      end
      last_mem <= '0;
    end else if (push && !flush_i) begin
      data_mem[wr_ptr] <= s_axis_tdata_i;
      user_mem[wr_ptr] <= s_axis_tuser_i;
      last_mem[wr_ptr] <= s_axis_tlast_i;
    end
  end

  assign m_axis_tdata_o = data_mem[rd_ptr];
  assign m_axis_tuser_o = user_mem[rd_ptr];
  assign m_axis_tlast_o = last_mem[rd_ptr];
  assign level_o        = level_q;

endmodule

// File: tb/tb_axis_fifo_slice.sv
// Directed and randomised checks of axis_fifo_slice (DEPTH=4, AF_THRESH=3, 4-bit tuser).
module tb_axis_fifo_slice;

  localparam int DW = 32;
  localparam int UW = 4;
  localparam int DEPTH = 4;
  localparam int LW = 3;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic          flush_i;
  logic [DW-1:0] s_axis_tdata_i;
  logic [UW-1:0] s_axis_tuser_i;
  logic          s_axis_tlast_i;
  logic          s_axis_tvalid_i;
  logic          s_axis_tready_o;
  logic [DW-1:0] m_axis_tdata_o;
  logic [UW-1:0] m_axis_tuser_o;
  logic          m_axis_tlast_o;
  logic          m_axis_tvalid_o;
  logic          m_axis_tready_i;
  logic [LW-1:0] level_o;
  logic          almost_full_o;

  int checks = 0;
  int passes = 0;

  axis_fifo_slice #(
    .DATA_WIDTH(DW),
    .USER_WIDTH(UW),
    .DEPTH(DEPTH),
    .AF_THRESH(3)
  ) dut (
    .clk_i(clk_i),
    .arstn_i(arstn_i),
    .flush_i(flush_i),
    .s_axis_tdata_i(s_axis_tdata_i),
    .s_axis_tuser_i(s_axis_tuser_i),
    .s_axis_tlast_i(s_axis_tlast_i),
    .s_axis_tvalid_i(s_axis_tvalid_i),
    .s_axis_tready_o(s_axis_tready_o),
    .m_axis_tdata_o(m_axis_tdata_o),
    .m_axis_tuser_o(m_axis_tuser_o),
    .m_axis_tlast_o(m_axis_tlast_o),
    .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tready_i(m_axis_tready_i),
    .level_o(level_o),
    .almost_full_o(almost_full_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [DW+UW+LW+3:0] obs;
    arstn_i = 1'b0;
    flush_i = 1'b0;
    s_axis_tdata_i = '0;
    s_axis_tuser_i = '0;
    s_axis_tlast_i = 1'b0;
    s_axis_tvalid_i = 1'b0;
    m_axis_tready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    obs = {s_axis_tready_o, m_axis_tvalid_o, m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o, level_o, almost_full_o};
    checks++;
    if (obs !== '0) $display("[TB] FAIL reset_outputs got %h want 0", obs);
    else passes++;
    arstn_i = 1'b1;
    step();
    checks++;
    if (s_axis_tready_o !== 1'b1) $display("[TB] FAIL ready_after_reset got %b want 1", s_axis_tready_o);
    else passes++;
  endtask

  task automatic test_stream();
    m_axis_tready_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_axis_tvalid_i = 1'b1;
      s_axis_tdata_i = DW'(i);
      step();
      checks++;
      if ({m_axis_tvalid_o, s_axis_tready_o, level_o, m_axis_tdata_o} !== {1'b1, 1'b1, 3'd1, DW'(i)})
        $display("[TB] FAIL stream_beat%0d got v=%b r=%b lvl=%0d d=%h want v=1 r=1 lvl=1 d=%h",
                 i, m_axis_tvalid_o, s_axis_tready_o, level_o, m_axis_tdata_o, i);
      else passes++;
    end
    s_axis_tvalid_i = 1'b0;
    step();
    checks++;
    if ({m_axis_tvalid_o, level_o} !== {1'b0, 3'd0})
      $display("[TB] FAIL stream_drain got v=%b lvl=%0d want v=0 lvl=0", m_axis_tvalid_o, level_o);
    else passes++;
  endtask

  task automatic test_fill();
    m_axis_tready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid_i = 1'b1;
      s_axis_tdata_i = 32'hA0 + DW'(i);
      step();
      checks++;
      if ({level_o, almost_full_o, m_axis_tdata_o} !== {LW'(i + 1), (i + 1 >= 3), 32'hA0})
        $display("[TB] FAIL fill_push%0d got lvl=%0d af=%b d=%h want lvl=%0d af=%b d=a0",
                 i, level_o, almost_full_o, m_axis_tdata_o, i + 1, (i + 1 >= 3));
      else passes++;
    end
    checks++;
    if (s_axis_tready_o !== 1'b0) $display("[TB] FAIL fill_ready got %b want 0", s_axis_tready_o);
    else passes++;
    s_axis_tdata_i = 32'hA4;
    step();
    checks++;
    if ({level_o, s_axis_tready_o, m_axis_tvalid_o, m_axis_tdata_o} !== {3'd4, 1'b0, 1'b1, 32'hA0})
      $display("[TB] FAIL fill_fifth got lvl=%0d r=%b v=%b d=%h want lvl=4 r=0 v=1 d=a0",
               level_o, s_axis_tready_o, m_axis_tvalid_o, m_axis_tdata_o);
    else passes++;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_d;
    m_axis_tready_i = 1'b1;
    step();
    m_axis_tready_i = 1'b0;
    checks++;
    if ({level_o, s_axis_tready_o, almost_full_o, m_axis_tdata_o} !== {3'd3, 1'b1, 1'b1, 32'hA1})
      $display("[TB] FAIL wrap_pop got lvl=%0d r=%b af=%b d=%h want lvl=3 r=1 af=1 d=a1",
               level_o, s_axis_tready_o, almost_full_o, m_axis_tdata_o);
    else passes++;
    step();
    checks++;
    if ({level_o, s_axis_tready_o} !== {3'd4, 1'b0})
      $display("[TB] FAIL wrap_refill got lvl=%0d r=%b want lvl=4 r=0", level_o, s_axis_tready_o);
    else passes++;
    s_axis_tvalid_i = 1'b0;
    m_axis_tready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_d = 32'hA0 + DW'(i);
      checks++;
      if ({m_axis_tvalid_o, m_axis_tdata_o} !== {1'b1, exp_d})
        $display("[TB] FAIL wrap_order%0d got v=%b d=%h want v=1 d=%h", i, m_axis_tvalid_o, m_axis_tdata_o, exp_d);
      else passes++;
      step();
    end
    checks++;
    if ({m_axis_tvalid_o, level_o, s_axis_tready_o} !== {1'b0, 3'd0, 1'b1})
      $display("[TB] FAIL wrap_empty got v=%b lvl=%0d r=%b want v=0 lvl=0 r=1", m_axis_tvalid_o, level_o, s_axis_tready_o);
    else passes++;
  endtask

  task automatic test_sideband();
    logic exp_last;
    m_axis_tready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_last = (i % 3 == 2);
      s_axis_tvalid_i = 1'b1;
      s_axis_tdata_i = 32'hC00 + DW'(i);
      s_axis_tuser_i = UW'(i);
      s_axis_tlast_i = exp_last;
      step();
      checks++;
      if ({m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o} !== {32'hC00 + DW'(i), UW'(i), exp_last})
        $display("[TB] FAIL sideband%0d got d=%h u=%h l=%b want d=%h u=%h l=%b", i,
                 m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o, 32'hC00 + i, i[UW-1:0], exp_last);
      else passes++;
    end
    s_axis_tvalid_i = 1'b0;
    s_axis_tlast_i = 1'b0;
    s_axis_tuser_i = '0;
    step();
  endtask

  task automatic test_flush();
    m_axis_tready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_axis_tvalid_i = 1'b1;
      s_axis_tdata_i = 32'hB0 + DW'(i);
      step();
    end
    checks++;
    if (level_o !== 3'd3) $display("[TB] FAIL flush_prefill got lvl=%0d want 3", level_o);
    else passes++;
    flush_i = 1'b1;
    s_axis_tdata_i = 32'hBF;
    step();
    flush_i = 1'b0;
    checks++;
    if ({level_o, m_axis_tvalid_o, s_axis_tready_o, almost_full_o} !== {3'd0, 1'b0, 1'b0, 1'b0})
      $display("[TB] FAIL flush_clear got lvl=%0d v=%b r=%b af=%b want all 0",
               level_o, m_axis_tvalid_o, s_axis_tready_o, almost_full_o);
    else passes++;
    s_axis_tdata_i = 32'hC0;
    step();
    checks++;
    if ({s_axis_tready_o, m_axis_tvalid_o} !== {1'b1, 1'b0})
      $display("[TB] FAIL flush_ready_back got r=%b v=%b want r=1 v=0", s_axis_tready_o, m_axis_tvalid_o);
    else passes++;
    step();
    s_axis_tvalid_i = 1'b0;
    checks++;
    if ({m_axis_tvalid_o, level_o, m_axis_tdata_o} !== {1'b1, 3'd1, 32'hC0})
      $display("[TB] FAIL flush_first_out got v=%b lvl=%0d d=%h want v=1 lvl=1 d=c0",
               m_axis_tvalid_o, level_o, m_axis_tdata_o);
    else passes++;
    m_axis_tready_i = 1'b1;
    step();
    checks++;
    if ({m_axis_tvalid_o, level_o} !== {1'b0, 3'd0})
      $display("[TB] FAIL flush_drain got v=%b lvl=%0d want v=0 lvl=0", m_axis_tvalid_o, level_o);
    else passes++;
  endtask

  task automatic test_random();
    localparam int NBEATS = 10000;
    localparam int CAP = 60000;
    logic [DW+UW:0] q[$];
    logic [DW+UW:0] beat;
    logic [DW+UW+LW+3:0] obs;
    int beats_in = 0;
    int beats_out = 0;
    int cyc = 0;
    bit rdy_en = 1'b1;
    bit reset_done = 1'b0;
    bit exp_valid, exp_ready, do_push, do_pop;
    while (beats_out < NBEATS && cyc < CAP) begin
      exp_valid = (q.size() != 0);
      exp_ready = rdy_en && (q.size() < DEPTH);
      checks++;
      if ({m_axis_tvalid_o, s_axis_tready_o, level_o, almost_full_o} !==
          {exp_valid, exp_ready, LW'(q.size()), (q.size() >= 3)})
        $display("[TB] FAIL rand_ctrl cyc%0d got v=%b r=%b lvl=%0d af=%b want v=%b r=%b lvl=%0d af=%b", cyc,
                 m_axis_tvalid_o, s_axis_tready_o, level_o, almost_full_o, exp_valid, exp_ready, q.size(), q.size() >= 3);
      else passes++;
      if (exp_valid) begin
        checks++;
        if ({m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o} !== q[0])
          $display("[TB] FAIL rand_data cyc%0d got %h want %h", cyc,
                   {m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o}, q[0]);
        else passes++;
      end
      s_axis_tvalid_i = (beats_in < NBEATS) && ($urandom_range(0, 3) != 0);
      s_axis_tdata_i = $urandom;
      s_axis_tuser_i = UW'($urandom);
      s_axis_tlast_i = 1'($urandom);
      m_axis_tready_i = ($urandom_range(0, 3) != 0);
      beat = {s_axis_tdata_i, s_axis_tuser_i, s_axis_tlast_i};
      do_push = s_axis_tvalid_i && exp_ready;
      do_pop = exp_valid && m_axis_tready_i;
      step();
      cyc++;
      rdy_en = 1'b1;
      if (do_pop) begin
        void'(q.pop_front());
        beats_out++;
      end
      if (do_push) begin
        q.push_back(beat);
        beats_in++;
      end
      if (!reset_done && beats_out >= NBEATS / 2) begin
        reset_done = 1'b1;
        arstn_i = 1'b0;
        #1;
        obs = {s_axis_tready_o, m_axis_tvalid_o, m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o, level_o, almost_full_o};
        checks++;
        if (obs !== '0) $display("[TB] FAIL rand_midreset got %h want 0", obs);
        else passes++;
        q.delete();
        beats_in = beats_out;
        s_axis_tvalid_i = 1'b0;
        #2;
        arstn_i = 1'b1;
        rdy_en = 1'b0;
      end
    end
    checks++;
    if (beats_out < NBEATS) $display("[TB] FAIL rand_timeout got %0d beats want %0d", beats_out, NBEATS);
    else passes++;
    s_axis_tvalid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_wrap();
    test_sideband();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
